baud_tick_seq_gen: RTL
======================

Name: baud_tick_seq_gen

Overview:
Parametrised successor to the UART 16/8-tick baud counter. It generates oversampling ticks from a programmable prescaler, with selectable oversampling of 8, 16 or 32. It also emits a mid-bit strobe and a bit-end strobe, and counts a programmable number of bit periods before a single-cycle done pulse. It sits between the register/PicoBlaze port interface and the UART TX/RX shift FSMs, which use tick, mid and bit_done.

Parameters:
PRESCALE_W, 20, width of prescale; tick period = prescale+1 clk cycles
NBITS_W, 4, width of nbits and bit_idx (max 2^NBITS_W-1 bit periods per run)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
prescale  in  PRESCALE_W  tick period minus 1; sampled on accepted load
ovs_mode  in  2  00=8, 01=16, 10=32, 11=16 (reserved, treated as 16); sampled on load
nbits  in  NBITS_W  bit periods per run; 0 treated as 1; sampled on load
cs  in  1  chip select/enable; low freezes the run
load  in  1  active-high start pulse; accepted only when cs=1
abort  in  1  active-high; terminates a run without done
tick  out  1  one-cycle oversample tick
mid  out  1  one-cycle pulse coincident with tick number OVS/2 of each bit
bit_done  out  1  one-cycle pulse coincident with tick number OVS of each bit
done  out  1  one-cycle pulse coincident with the last bit_done
busy  out  1  high while a run is active
bit_idx  out  NBITS_W  index of the current bit period, 0-based

Behaviour:
- Reset (async): all outputs 0, FSM IDLE, all counters 0, latched config 0. Reset mid-run kills the run with no done.
- All outputs are registered.
- FSM has 2 states: IDLE and RUN.
- IDLE->RUN: at edge E0 where load=1, cs=1 and abort=0. Latch P=prescale, OVS, N=max(nbits,1). Clear the prescale count pc, tick count tc and bit_idx. busy=1 after E0.
- Prescaler, RUN with cs=1: pc increments each cycle. When pc==P, pc wraps to 0 and tick is high for the following cycle.
  - First tick is high after edge E0+P+1; subsequent ticks are every P+1 cycles.
  - P=0 gives a tick every cycle.
  - P=2^PRESCALE_W-1 is legal, with no overflow (pc uses the same width).
- Tick count: tc counts ticks 1..OVS within a bit.
  - mid asserts with the tick where tc==OVS/2 (4, 8 or 16).
  - bit_done asserts with the tick where tc==OVS. tc then returns to 0 and bit_idx increments.
- Completion: the N-th bit_done asserts done in the same cycle. busy drops, the FSM goes to IDLE and bit_idx returns to 0 after that edge. Total run length is N*OVS*(P+1) cycles from E0 to done visible.
- cs=0 in RUN: pc, tc and bit_idx hold. tick, mid, bit_done and done are forced 0. busy stays 1. The run resumes exactly where it paused when cs returns to 1.
- cs=0 blocks load in any state. cs does not gate abort.
- abort=1 in RUN: next edge goes to IDLE, busy=0, counters clear, no done. abort in IDLE has no effect.
- abort and load in the same cycle: abort wins, and the FSM ends in IDLE.
- load in RUN (cs=1, abort=0) retriggers the run. The new config is latched, counters clear, and there is no done for the interrupted run. If load coincides with the final bit_done, done is suppressed and the new run starts.
- Config inputs are ignored except at an accepted load.

Decomposition:
- Shared package uart_pkg:
  - ovs_mode encodings: OVS_8=2'b00, OVS_16=2'b01, OVS_32=2'b10.
  - Function ovs_count(mode) returning 8, 16 or 32 (16 for 2'b11).
  - FSM state typedef with IDLE and RUN.
- One sub-module: baud_prescaler. Inputs are clk, reset, en, clr and P; its output is the tick strobe. It is parameterised by PRESCALE_W.
- The tick/bit counters and FSM stay in the top module.

Test Plan:
1. P=0, ovs_mode=00, nbits=1, load at E0 -> tick high for cycles E0+1..E0+8; mid with the 4th tick; bit_done, done and busy falling with the 8th tick (done after E0+8).
2. P=9, ovs_mode=01, nbits=10 -> 160 ticks spaced 10 cycles apart; bit_idx steps 0..9; done exactly 1600 cycles after E0; 10 mid and 10 bit_done pulses.
3. Same as 2, with cs=0 for 50 cycles starting at cycle 400 -> no strobes during the pause; done at cycle 1650; busy stays high throughout.
4. P=3, ovs_mode=10, nbits=0 -> treated as 1 bit; mid at the 16th tick; done at cycle 128. Repeat with ovs_mode=11 -> done at cycle 64.
5. Retrigger: start P=1, ovs16, nbits=2, then load P=0, ovs8, nbits=1 at cycle 20 -> no done for the first run; done 8 cycles after the second load. Abort+load in the same cycle -> IDLE, busy=0, no ticks.
6. Async reset asserted at cycle 37 of run 2 (no clock edge needed) -> all outputs 0 immediately; no done after deassertion; a following load starts a clean run.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART baud/tick encodings, FSM state type and helpers
//
// Purpose: oversampling mode encodings, the oversample-count decode and the
// two-state run FSM type used by the baud tick sequence generator.
package uart_pkg;

  localparam logic [1:0] OVS_8  = 2'b00;
  localparam logic [1:0] OVS_16 = 2'b01;
  localparam logic [1:0] OVS_32 = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Ticks per bit period; the reserved encoding 2'b11 behaves as 16.
  function automatic logic [5:0] ovs_count(input logic [1:0] mode);
    case (mode)
      OVS_8:   return 6'd8;
      OVS_16:  return 6'd16;
      OVS_32:  return 6'd32;
      default: return 6'd16;
    endcase
  endfunction

endpackage

// File: rtl/baud_prescaler.sv
// rtl/baud_prescaler.sv - programmable prescaler producing one strobe per p+1 enabled cycles
//
// Purpose: free-running modulo-(p+1) counter advanced while en is high.
// Ports:
//   clk   in   system clock
//   reset in   asynchronous active-high reset, clears the count
//   en    in   advance the count this cycle
//   clr   in   synchronous clear of the count (wins over en)
//   p     in   PRESCALE_W  terminal count (period minus 1)
//   tick  out  combinational strobe, high in the cycle the count wraps
module baud_prescaler #(
  parameter int PRESCALE_W = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] p,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pc;

  // The count never exceeds p, so p = all-ones cannot overflow pc.
  assign tick = en && !clr && (pc == p);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (clr) begin
      pc <= '0;
    end else if (en) begin
      if (pc == p) begin
        pc <= '0;
      end else begin
        pc <= pc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/baud_tick_seq_gen.sv
// rtl/baud_tick_seq_gen.sv - oversampling tick, mid-bit and bit-end strobe sequencer
//
// Purpose: runs N bit periods of OVS ticks each, every tick P+1 clocks apart,
// pulsing mid at tick OVS/2, bit_done at tick OVS and done on the last bit_done.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   prescale, ovs_mode,    run configuration, sampled only on an accepted load
//   nbits
//   cs                     enable; low freezes a run and blocks load
//   load, abort            start/retrigger pulse, run termination (abort wins)
//   tick, mid, bit_done,   registered one-cycle strobes
//   done
//   busy, bit_idx          run active flag, current 0-based bit period
module baud_tick_seq_gen
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = 20,
  parameter int NBITS_W    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [1:0]            ovs_mode,
  input  logic [NBITS_W-1:0]    nbits,
  input  logic                  cs,
  input  logic                  load,
  input  logic                  abort,
  output logic                  tick,
  output logic                  mid,
  output logic                  bit_done,
  output logic                  done,
  output logic                  busy,
  output logic [NBITS_W-1:0]    bit_idx
);

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic [5:0]            ovs_q, ovs_d;
  logic [NBITS_W-1:0]    n_q, n_d;
  logic [5:0]            tc_q, tc_d;
  logic [NBITS_W-1:0]    idx_d;
  logic                  tick_d, mid_d, bd_d, done_d;
  logic                  pre_en, pre_clr, pre_tick;
  logic [5:0]            tc_inc;

  assign tc_inc = tc_q + 6'd1;

  baud_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (pre_en),
    .clr  (pre_clr),
    .p    (p_q),
    .tick (pre_tick)
  );

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    ovs_d   = ovs_q;
    n_d     = n_q;
    tc_d    = tc_q;
    idx_d   = bit_idx;
    tick_d  = 1'b0;
    mid_d   = 1'b0;
    bd_d    = 1'b0;
    done_d  = 1'b0;
    pre_en  = 1'b0;
    pre_clr = 1'b0;

    case (state_q)
      IDLE: begin
        if (load && cs && !abort) begin
          state_d = RUN;
          p_d     = prescale;
          ovs_d   = ovs_count(ovs_mode);
          n_d     = (nbits == '0) ? NBITS_W'(1) : nbits;
          tc_d    = '0;
          idx_d   = '0;
          pre_clr = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          tc_d    = '0;
          idx_d   = '0;
          pre_clr = 1'b1;
        end else if (load && cs) begin
          // Retrigger: any strobe of the interrupted run, including its done, is dropped.
          p_d     = prescale;
          ovs_d   = ovs_count(ovs_mode);
          n_d     = (nbits == '0) ? NBITS_W'(1) : nbits;
          tc_d    = '0;
          idx_d   = '0;
          pre_clr = 1'b1;
        end else if (cs) begin
          pre_en = 1'b1;
          if (pre_tick) begin
            tick_d = 1'b1;
            mid_d  = (tc_inc == (ovs_q >> 1));
            if (tc_inc == ovs_q) begin
              bd_d = 1'b1;
              tc_d = '0;
              if (bit_idx == n_q - NBITS_W'(1)) begin
                // The prescaler has just wrapped to 0, so IDLE starts clean.
                done_d  = 1'b1;
                state_d = IDLE;
                idx_d   = '0;
              end else begin
                idx_d = bit_idx + NBITS_W'(1);
              end
            end else begin
              tc_d = tc_inc;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      p_q      <= '0;
      ovs_q    <= '0;
      n_q      <= '0;
      tc_q     <= '0;
      bit_idx  <= '0;
      tick     <= 1'b0;
      mid      <= 1'b0;
      bit_done <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      ovs_q    <= ovs_d;
      n_q      <= n_d;
      tc_q     <= tc_d;
      bit_idx  <= idx_d;
      tick     <= tick_d;
      mid      <= mid_d;
      bit_done <= bd_d;
      done     <= done_d;
      busy     <= (state_d == RUN);
    end
  end

endmodule
